// File: rtl/execute_if.sv
// Operand/result bundle between the operand-read stage and the execute stage.
// The read stage is the master; the execute stage is the slave.
interface execute_if #(
  parameter int WIDTH = 16
);
  logic             alu_en;
  logic             src_a_en;
  logic [WIDTH-1:0] src_a;
  logic             src_b_en;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       truth_table;
  logic [4:0]       alu_op;
  logic [3:0]       sh_off;
  logic             busy;
  logic             res_valid;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output alu_en, src_a_en, src_a, src_b_en, src_b, truth_table, alu_op, sh_off,
    input  busy, res_valid, result, flag_z, flag_n, flag_c
  );

  modport slave (
    input  alu_en, src_a_en, src_a, src_b_en, src_b, truth_table, alu_op, sh_off,
    output busy, res_valid, result, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/execute.sv
// ALU/execute stage: single-cycle logic, add/sub and compare; shifts iterate one bit
// per cycle (or finish at once when FAST_SHIFT=1) with busy stalling the read stage.
module execute #(
  parameter int WIDTH      = 16,
  parameter bit FAST_SHIFT = 1'b0
) (
  input logic      cpu_clk,
  input logic      cpu_rst,
  execute_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [1:0]       kind, kind_nxt;
  logic             res_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_z_q, flag_n_q, flag_c_q;

  logic [WIDTH-1:0] a_op, b_op, b_eff;
  logic             sub, lt;
  logic [WIDTH:0]   sum, fast, step;
  logic             commit, commit_c;
  logic [WIDTH-1:0] commit_res;
  logic             unused_op_bit;

  // Returns {bit shifted out (ROL: bit rotated in), shifted word} for one step.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] w,
                                                input logic [1:0]       k);
    case (k)
      2'b00:   return {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      2'b01:   return {w[0], 1'b0, w[WIDTH-1:1]};
      2'b10:   return {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      default: return {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
    endcase
  endfunction

  assign a_op          = bus.src_a_en ? bus.src_a : '0;
  assign b_op          = bus.src_b_en ? bus.src_b : '0;
  assign sub           = bus.alu_op[0];
  assign b_eff         = sub ? ~b_op : b_op;
  assign sum           = {1'b0, a_op} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign lt            = bus.alu_op[0] ? (a_op < b_op) : ($signed(a_op) < $signed(b_op));
  assign unused_op_bit = bus.alu_op[2];

  // Unrolled barrel shift: sh_off iterations of the same single-bit step.
  always_comb begin
    fast = {1'b0, a_op};
    for (int i = 1; i < 16; i++) begin
      if (i <= int'(bus.sh_off)) fast = shift_step(fast[WIDTH-1:0], bus.alu_op[1:0]);
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    cnt_nxt    = cnt;
    kind_nxt   = kind;
    commit     = 1'b0;
    commit_res = '0;
    commit_c   = 1'b0;
    step       = '0;
    case (state)
      IDLE: begin
        if (bus.alu_en) begin
          case (bus.alu_op[4:3])
            2'b00: begin
              commit = 1'b1;
              for (int i = 0; i < WIDTH; i++) commit_res[i] = bus.truth_table[{a_op[i], b_op[i]}];
            end
            2'b01: begin
              commit                 = 1'b1;
              {commit_c, commit_res} = sum;
            end
            2'b10: begin
              if (FAST_SHIFT || bus.sh_off == 4'd0) begin
                commit                 = 1'b1;
                {commit_c, commit_res} = fast;
              end else begin
                // The first step happens in the accept cycle, so a shift by k ends k cycles later.
                step = shift_step(a_op, bus.alu_op[1:0]);
                if (bus.sh_off == 4'd1) begin
                  commit                 = 1'b1;
                  {commit_c, commit_res} = step;
                end else begin
                  state_nxt = SHIFT;
                  work_nxt  = step[WIDTH-1:0];
                  cnt_nxt   = bus.sh_off - 4'd1;
                  kind_nxt  = bus.alu_op[1:0];
                end
              end
            end
            default: begin
              commit     = 1'b1;
              commit_res = {{(WIDTH-1){1'b0}}, lt};
              commit_c   = ~lt;
            end
          endcase
        end
      end
      SHIFT: begin
        step     = shift_step(work, kind);
        work_nxt = step[WIDTH-1:0];
        cnt_nxt  = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit                 = 1'b1;
          {commit_c, commit_res} = step;
          state_nxt              = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      kind        <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      work        <= work_nxt;
      cnt         <= cnt_nxt;
      kind        <= kind_nxt;
      res_valid_q <= commit;
      if (commit) begin
        result_q <= commit_res;
        flag_z_q <= (commit_res == '0);
        flag_n_q <= commit_res[WIDTH-1];
        flag_c_q <= commit_c;
      end
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_c    = flag_c_q;
endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed scenarios plus randomized ops compared
// against a plain-arithmetic reference model.
module tb_execute;
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  execute_if #(.WIDTH(16)) bus ();
  execute #(.WIDTH(16), .FAST_SHIFT(1'b0)) dut (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus));

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Reference: result, carry and latency straight from the operation definitions.
  task automatic ref_model(input logic a_en, input logic [15:0] a_in, input logic b_en,
                           input logic [15:0] b_in, input logic [3:0] tt, input logic [4:0] op,
                           input logic [3:0] sh, output logic [15:0] r, output logic c,
                           output int lat);
    logic [15:0] a, b;
    int k, s;
    logic lt;
    a = a_en ? a_in : 16'h0;
    b = b_en ? b_in : 16'h0;
    k = int'(sh);
    r = 16'h0; c = 1'b0; lat = 1;
    case (op[4:3])
      2'b00: for (int i = 0; i < 16; i++) r[i] = tt[{a[i], b[i]}];
      2'b01: begin
        if (op[0]) begin r = a - b; c = (a >= b); end
        else begin s = int'(a) + int'(b); r = 16'(s); c = (s > 65535); end
      end
      2'b10: begin
        if (k == 0) r = a;
        else begin
          lat = k;
          case (op[1:0])
            2'b00: begin r = a << k; c = a[16-k]; end
            2'b01: begin r = a >> k; c = a[k-1]; end
            2'b10: begin r = 16'($signed(a) >>> k); c = a[k-1]; end
            default: begin r = (a << k) | (a >> (16 - k)); c = r[0]; end
          endcase
        end
      end
      default: begin
        lt = op[0] ? (a < b) : ($signed(a) < $signed(b));
        r = {15'h0, lt};
        c = ~lt;
      end
    endcase
  endtask

  // Drives one op, waits (bounded) for res_valid, reports latency, busy cycles and outputs.
  task automatic run_op(input logic a_en, input logic [15:0] a, input logic b_en,
                        input logic [15:0] b, input logic [3:0] tt, input logic [4:0] op,
                        input logic [3:0] sh, input bit hold, output int lat,
                        output int busy_n, output logic [19:0] obs);
    bus.alu_en = 1'b1; bus.src_a_en = a_en; bus.src_a = a; bus.src_b_en = b_en;
    bus.src_b = b; bus.truth_table = tt; bus.alu_op = op; bus.sh_off = sh;
    tick();
    lat = 1; busy_n = 0;
    if (!hold) bus.alu_en = 1'b0;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      if (hold) begin
        bus.src_a = 16'($urandom); bus.alu_op = 5'($urandom); bus.sh_off = 4'($urandom);
      end
      tick();
      lat++;
    end
    bus.alu_en = 1'b0;
    obs = {bus.busy, bus.result, bus.flag_z, bus.flag_n, bus.flag_c};
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.busy, bus.res_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c} !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b rv=%b res=%h z=%b n=%b c=%b, want all 0",
               bus.busy, bus.res_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c);
    end
  endtask

  task automatic test_logic();
    int lat, bn; logic [19:0] obs;
    run_op(1, 16'hF0F0, 1, 16'hFF00, 4'b0110, 5'b00000, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if ({lat, obs} !== {32'd1, 1'b0, 16'h0FF0, 3'b000}) begin
      tests_failed++;
      $display("FAIL logic_xor: got lat=%0d obs=%h, want lat=1 obs=%h", lat, obs, {1'b0, 16'h0FF0, 3'b000});
    end
  endtask

  task automatic test_arith();
    int lat, bn; logic [19:0] obs;
    run_op(1, 16'hFFFF, 1, 16'h0001, 4'h0, 5'b01000, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if ({lat, obs} !== {32'd1, 1'b0, 16'h0000, 3'b101}) begin
      tests_failed++;
      $display("FAIL add_wrap: got lat=%0d obs=%h, want lat=1 obs=%h", lat, obs, {1'b0, 16'h0000, 3'b101});
    end
    run_op(1, 16'h0001, 1, 16'h0002, 4'h0, 5'b01001, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if ({lat, obs} !== {32'd1, 1'b0, 16'hFFFF, 3'b010}) begin
      tests_failed++;
      $display("FAIL sub_borrow: got lat=%0d obs=%h, want lat=1 obs=%h", lat, obs, {1'b0, 16'hFFFF, 3'b010});
    end
  endtask

  task automatic test_shift_sra();
    int lat, bn; logic [19:0] obs;
    run_op(1, 16'h8001, 1, 16'h0000, 4'h0, 5'b10010, 4'd4, 1, lat, bn, obs);
    tests_run++;
    if ({lat, bn} !== {32'd4, 32'd3}) begin
      tests_failed++;
      $display("FAIL sra_timing: got lat=%0d busy=%0d, want lat=4 busy=3", lat, bn);
    end
    tests_run++;
    if (obs !== {1'b0, 16'hF800, 3'b010}) begin
      tests_failed++;
      $display("FAIL sra_result: got %h, want %h", obs, {1'b0, 16'hF800, 3'b010});
    end
  endtask

  task automatic test_rol_zero();
    int lat, bn; logic [19:0] obs;
    run_op(1, 16'h8001, 1, 16'h0000, 4'h0, 5'b10011, 4'd1, 0, lat, bn, obs);
    tests_run++;
    if ({lat, bn, obs} !== {32'd1, 32'd0, 1'b0, 16'h0003, 3'b001}) begin
      tests_failed++;
      $display("FAIL rol_1: got lat=%0d busy=%0d obs=%h, want 1 0 %h", lat, bn, obs, {1'b0, 16'h0003, 3'b001});
    end
    run_op(1, 16'h8001, 1, 16'h0000, 4'h0, 5'b10000, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if ({lat, bn, obs} !== {32'd1, 32'd0, 1'b0, 16'h8001, 3'b010}) begin
      tests_failed++;
      $display("FAIL shift_0: got lat=%0d busy=%0d obs=%h, want 1 0 %h", lat, bn, obs, {1'b0, 16'h8001, 3'b010});
    end
  endtask

  task automatic test_cmp_enables();
    int lat, bn; logic [19:0] obs;
    run_op(1, 16'hFFFF, 1, 16'h0001, 4'h0, 5'b11000, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if (obs !== {1'b0, 16'h0001, 3'b000}) begin
      tests_failed++;
      $display("FAIL cmp_signed: got %h, want %h", obs, {1'b0, 16'h0001, 3'b000});
    end
    run_op(1, 16'hFFFF, 1, 16'h0001, 4'h0, 5'b11001, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if (obs !== {1'b0, 16'h0000, 3'b101}) begin
      tests_failed++;
      $display("FAIL cmp_unsigned: got %h, want %h", obs, {1'b0, 16'h0000, 3'b101});
    end
    run_op(0, 16'hFFFF, 1, 16'h0001, 4'h0, 5'b11001, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if (obs !== {1'b0, 16'h0001, 3'b000}) begin
      tests_failed++;
      $display("FAIL src_a_en_off: got %h, want %h", obs, {1'b0, 16'h0001, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.alu_en = 1; bus.src_a_en = 1; bus.src_a = 16'h0001; bus.src_b_en = 1; bus.src_b = 16'h0;
    bus.alu_op = 5'b10000; bus.sh_off = 4'd3; bus.truth_table = 4'h0;
    tick();
    bus.alu_en = 0;
    n = 1;
    while (bus.res_valid !== 1'b1 && n < 40) begin tick(); n++; end
    tests_run++;
    if ({n, bus.busy, bus.result, bus.flag_c} !== {32'd3, 1'b0, 16'h0008, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d busy=%b res=%h c=%b, want 3 0 0008 0", n, bus.busy, bus.result, bus.flag_c);
    end
    bus.alu_en = 1; bus.src_a = 16'h1234; bus.src_b = 16'h0001; bus.alu_op = 5'b01000; bus.sh_off = 4'd0;
    tick();
    bus.alu_en = 0;
    tests_run++;
    if ({bus.res_valid, bus.result} !== {1'b1, 16'h1235}) begin
      tests_failed++;
      $display("FAIL b2b_second: got rv=%b res=%h, want 1 1235", bus.res_valid, bus.result);
    end
    tick();
    tests_run++;
    if ({bus.res_valid, bus.result} !== {1'b0, 16'h1235}) begin
      tests_failed++;
      $display("FAIL pulse_hold: got rv=%b res=%h, want 0 1235", bus.res_valid, bus.result);
    end
  endtask

  task automatic test_random();
    int lat, bn, exp_lat;
    logic [19:0] obs;
    logic [15:0] a, b, er;
    logic [4:0] op;
    logic [3:0] tt, sh;
    logic ae, be, ec;
    bit hold;
    for (int it = 0; it < 80; it++) begin
      a = 16'($urandom); b = 16'($urandom); op = 5'($urandom); tt = 4'($urandom);
      sh = 4'($urandom); ae = ($urandom_range(0, 7) != 0); be = ($urandom_range(0, 7) != 0);
      hold = ($urandom_range(0, 1) == 1);
      if (it % 4 == 0) a = (it % 8 == 0) ? 16'h8000 : 16'h7FFF;
      ref_model(ae, a, be, b, tt, op, sh, er, ec, exp_lat);
      run_op(ae, a, be, b, tt, op, sh, hold, lat, bn, obs);
      tests_run++;
      if ({lat, bn, obs} !== {exp_lat, exp_lat - 1, 1'b0, er, (er == 16'h0), er[15], ec}) begin
        tests_failed++;
        $display("FAIL random_%0d: op=%b sh=%0d a=%h b=%h got lat=%0d busy=%0d obs=%h, want lat=%0d busy=%0d obs=%h",
                 it, op, sh, a, b, lat, bn, obs, exp_lat, exp_lat - 1, {1'b0, er, (er == 16'h0), er[15], ec});
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bn; logic [19:0] obs;
    run_op(1, 16'hF0F0, 1, 16'hFF00, 4'b0110, 5'b00000, 4'd0, 0, lat, bn, obs);
    bus.alu_en = 1; bus.src_a = 16'h8001; bus.alu_op = 5'b10010; bus.sh_off = 4'd8;
    tick();
    bus.alu_en = 0;
    tick();
    tests_run++;
    if ({bus.busy, bus.result} !== {1'b1, 16'h0FF0}) begin
      tests_failed++;
      $display("FAIL mid_shift_busy: got busy=%b res=%h, want 1 0ff0", bus.busy, bus.result);
    end
    #2 cpu_rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.res_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c} !== 21'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%b rv=%b res=%h flags=%b%b%b, want all 0",
               bus.busy, bus.res_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c);
    end
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    run_op(1, 16'h0003, 1, 16'h0004, 4'h0, 5'b01000, 4'd0, 0, lat, bn, obs);
    tests_run++;
    if ({lat, obs} !== {32'd1, 1'b0, 16'h0007, 3'b000}) begin
      tests_failed++;
      $display("FAIL after_reset: got lat=%0d obs=%h, want 1 %h", lat, obs, {1'b0, 16'h0007, 3'b000});
    end
  endtask

  initial begin
    bus.alu_en = 0; bus.src_a_en = 0; bus.src_a = '0; bus.src_b_en = 0; bus.src_b = '0;
    bus.truth_table = '0; bus.alu_op = '0; bus.sh_off = '0;
    repeat (3) @(negedge cpu_clk);
    test_reset();
    cpu_rst = 1'b1;
    tick();
    test_logic();
    test_arith();
    test_shift_sra();
    test_rol_zero();
    test_cmp_enables();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
